// File: rtl/fft_seq_pkg.sv
// Shared types and constants for the FFT frame sequencer.
// Beats carry four complex lanes, X0 at the MSB end.
package fft_seq_pkg;

  localparam int LANES = 4;
  localparam int COMP_PER_BEAT = 2 * LANES;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_STREAM,
    S_GAP
  } state_t;

  function automatic int beat_w(input int dw);
    return COMP_PER_BEAT * dw;
  endfunction

  // Lane n: X at component slot 2n, Y at 2n+1, counted from the MSB.
  function automatic int lane_x_lsb(input int lane, input int dw);
    return (COMP_PER_BEAT - 1 - 2 * lane) * dw;
  endfunction

  function automatic int lane_y_lsb(input int lane, input int dw);
    return (COMP_PER_BEAT - 2 - 2 * lane) * dw;
  endfunction

endpackage

// File: rtl/fft_frame_sequencer_fifo.sv
// Synchronous show-ahead FIFO with occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module fft_seq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (i_pop)  r_rptr <= r_rptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frame sequencer for the streaming dft_top core: buffers a frame,
// strobes next, streams it gap-free, and captures the output frame.
module fft_frame_sequencer
  import fft_seq_pkg::*;
#(
  parameter int DATA_W      = 24,
  parameter int FRAME_WORDS = 16,
  parameter int GAP_CYCLES  = 2,
  parameter int MAX_LAT     = 1023
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*DATA_W-1:0] in_data,
  output logic                fft_next,
  output logic [8*DATA_W-1:0] fft_in,
  input  logic                fft_next_out,
  input  logic [8*DATA_W-1:0] fft_out,
  output logic                out_valid,
  output logic                out_last,
  output logic [8*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]    frames_in,
  output logic [CNT_W-1:0]    frames_out,
  output logic                err_timeout,
  output logic                err_overlap,
  output logic                busy
);

  localparam int BEAT_W = beat_w(DATA_W);
  localparam int DEPTH  = 2 * FRAME_WORDS;
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int BC     = $clog2(FRAME_WORDS);
  localparam int GW     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int WW     = $clog2(MAX_LAT + 1);

  logic [CW-1:0]     w_count;
  logic [BEAT_W-1:0] w_rdata;
  logic              w_push;
  logic              w_pop;
  logic              w_wd_run;
  logic              w_timeout;

  state_t            r_state;
  logic              r_fft_next;
  logic [BEAT_W-1:0] r_fft_in;
  logic [BC-1:0]     r_beat;
  logic [GW-1:0]     r_gap;
  logic [CNT_W-1:0]  r_frames_in;

  logic [1:0]        r_in_flight;
  logic [WW-1:0]     r_wd;
  logic              r_err_timeout;

  logic              r_cap_active;
  logic [BC-1:0]     r_cap_cnt;
  logic              r_out_valid;
  logic              r_out_last;
  logic [BEAT_W-1:0] r_out_data;
  logic [CNT_W-1:0]  r_frames_out;
  logic              r_err_overlap;

  assign in_ready = ~reset & (w_count < CW'(DEPTH));
  assign w_push   = in_valid & in_ready;
  // Beat k is popped one cycle before it shows on fft_in.
  assign w_pop    = (r_state == S_PRIME) | (r_state == S_STREAM);

  fft_seq_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_push  (w_push),
    .i_wdata (in_data),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_count (w_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_fft_next  <= 1'b0;
      r_fft_in    <= '0;
      r_beat      <= '0;
      r_gap       <= '0;
      r_frames_in <= '0;
    end else begin
      r_fft_in   <= w_pop ? w_rdata : '0;
      r_fft_next <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_count >= CW'(FRAME_WORDS)) begin
            r_state    <= S_PRIME;
            r_fft_next <= 1'b1;
          end
        end
        S_PRIME: begin
          r_frames_in <= r_frames_in + CNT_W'(1);
          r_beat      <= BC'(1);
          r_state     <= S_STREAM;
        end
        S_STREAM: begin
          r_beat <= r_beat + BC'(1);
          if (r_beat == BC'(FRAME_WORDS - 1)) begin
            r_gap   <= '0;
            r_state <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          end
        end
        S_GAP: begin
          if (r_gap == GW'(GAP_CYCLES - 1)) r_state <= S_IDLE;
          else r_gap <= r_gap + GW'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The strobe cycle itself counts toward the core latency budget.
  assign w_wd_run  = (r_in_flight != 2'd0) | r_fft_next;
  assign w_timeout = ~fft_next_out & w_wd_run
                   & (r_wd == WW'(MAX_LAT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_flight   <= '0;
      r_wd          <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      if (fft_next_out) r_wd <= '0;
      else if (w_timeout) r_wd <= '0;
      else if (w_wd_run) r_wd <= r_wd + WW'(1);

      if (w_timeout) begin
        r_err_timeout <= 1'b1;
        r_in_flight   <= '0;
      end else begin
        case ({r_fft_next, fft_next_out})
          2'b10: if (r_in_flight != 2'd3)
                   r_in_flight <= r_in_flight + 2'd1;
          2'b01: if (r_in_flight != 2'd0)
                   r_in_flight <= r_in_flight - 2'd1;
          default: r_in_flight <= r_in_flight;
        endcase
      end
    end
  end

  // A new next_out always wins; an interrupted frame is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cap_active  <= 1'b0;
      r_cap_cnt     <= '0;
      r_out_valid   <= 1'b0;
      r_out_last    <= 1'b0;
      r_out_data    <= '0;
      r_frames_out  <= '0;
      r_err_overlap <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      if (fft_next_out) begin
        r_cap_active <= 1'b1;
        r_cap_cnt    <= '0;
        if (r_cap_active) r_err_overlap <= 1'b1;
      end else if (r_cap_active) begin
        r_out_valid <= 1'b1;
        r_out_data  <= fft_out;
        r_cap_cnt   <= r_cap_cnt + BC'(1);
        if (r_cap_cnt == BC'(FRAME_WORDS - 1)) begin
          r_out_last   <= 1'b1;
          r_frames_out <= r_frames_out + CNT_W'(1);
          r_cap_active <= 1'b0;
        end
      end
    end
  end

  assign fft_next    = r_fft_next;
  assign fft_in      = r_fft_in;
  assign out_valid   = r_out_valid;
  assign out_last    = r_out_last;
  assign out_data    = r_out_data;
  assign frames_in   = r_frames_in;
  assign frames_out  = r_frames_out;
  assign err_timeout = r_err_timeout;
  assign err_overlap = r_err_overlap;
  assign busy        = (r_state != S_IDLE) | r_cap_active;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer (FRAME_WORDS=16, MAX_LAT=15).
// Inputs driven and outputs sampled on the falling edge.
module tb_fft_frame_sequencer;

  localparam int DW = 24;
  localparam int FW = 16;
  localparam int BW = 8 * DW;
  localparam int ML = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_data;
  logic          fft_next;
  logic [BW-1:0] fft_in;
  logic          fft_next_out;
  logic [BW-1:0] fft_out;
  logic          out_valid;
  logic          out_last;
  logic [BW-1:0] out_data;
  logic [15:0]   frames_in;
  logic [15:0]   frames_out;
  logic          err_timeout;
  logic          err_overlap;
  logic          busy;

  always #5 clk = ~clk;

  fft_frame_sequencer #(
    .DATA_W      (DW),
    .FRAME_WORDS (FW),
    .GAP_CYCLES  (2),
    .MAX_LAT     (ML)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .fft_next     (fft_next),
    .fft_in       (fft_in),
    .fft_next_out (fft_next_out),
    .fft_out      (fft_out),
    .out_valid    (out_valid),
    .out_last     (out_last),
    .out_data     (out_data),
    .frames_in    (frames_in),
    .frames_out   (frames_out),
    .err_timeout  (err_timeout),
    .err_overlap  (err_overlap),
    .busy         (busy)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [BW-1:0] got,
                       input logic [BW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame monitor: collects streamed beats and idle gaps.
  int            cyc = 0;
  int            n_next = 0;
  int            last_end = -1;
  int            bk = 0;
  bit            strm = 1'b0;
  logic [BW-1:0] got_q [$];
  int            gaps [$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (reset) begin
      strm = 1'b0;
      last_end = -1;
    end else if (fft_next) begin
      n_next++;
      if (last_end >= 0) gaps.push_back(cyc - last_end - 1);
      strm = 1'b1;
      bk = 0;
    end else if (strm) begin
      got_q.push_back(fft_in);
      bk++;
      if (bk == FW) begin
        strm = 1'b0;
        last_end = cyc;
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    fft_next_out = 1'b0;
    fft_out = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic push_n(input int n, input int base_v);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in_data = BW'(base_v + k);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  int  mcount, rem, pushed, bad_rdy, bad_d, base, gbase;
  int  mn, rise, lasts, nb;
  bit  saw_low, stop_push, fin, go, push, pop, found;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    in_valid = 1'b0;
    in_data = '0;
    fft_next_out = 1'b0;
    fft_out = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_rdy", BW'(in_ready), BW'(0));
    check("rst_fft_in", fft_in, '0);
    check("rst_out_data", out_data, '0);
    check("rst_frames", BW'({frames_in, frames_out}), BW'(0));
    check("rst_flags", BW'({err_timeout, err_overlap, busy,
                            out_valid, out_last, fft_next}), BW'(0));
    reset = 1'b0;
    @(negedge clk);
    check("rdy_after_rst", BW'(in_ready), BW'(1));

    // Test 1: one frame, beats 1..16
    push_n(16, 1);
    check("t1_next_early", BW'(fft_next), BW'(0));
    @(negedge clk);
    check("t1_next", BW'(fft_next), BW'(1));
    check("t1_fin_pre", BW'(frames_in), BW'(0));
    for (int k = 1; k <= FW; k++) begin
      @(negedge clk);
      check("t1_beat", fft_in, BW'(k));
      if (fft_next) check("t1_next_once", BW'(fft_next), BW'(0));
    end
    check("t1_frames_in", BW'(frames_in), BW'(1));
    @(negedge clk);
    check("t1_gap_zero", fft_in, '0);

    // Test 2: stalled then continuous source, in_ready model
    do_reset();
    mcount = 0; rem = 0; pushed = 0; bad_rdy = 0;
    saw_low = 0; stop_push = 0; fin = 0;
    base = got_q.size();
    gbase = gaps.size();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (in_ready !== (mcount < 2 * FW)) bad_rdy++;
      if (!in_ready) saw_low = 1;
      if (saw_low && (pushed % FW) == 0) stop_push = 1;
      go = !stop_push && (pushed >= 40 || $urandom_range(0, 2) != 0);
      in_valid = go;
      in_data = BW'(1000 + pushed);
      push = go && in_ready;
      if (push) pushed++;
      pop = fft_next || rem > 0;
      mcount = mcount + int'(push) - int'(pop);
      if (fft_next) rem = FW - 1;
      else if (rem > 0) rem--;
      if (stop_push && mcount == 0 && rem == 0 && !busy) begin
        fin = 1;
        break;
      end
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("t2_finished", BW'(fin), BW'(1));
    check("t2_rdy_model", BW'(bad_rdy), BW'(0));
    check("t2_full_seen", BW'(saw_low), BW'(1));
    check("t2_nbeats", BW'(got_q.size() - base), BW'(pushed));
    bad_d = 0;
    for (int i = 0; i < got_q.size() - base; i++)
      if (got_q[base + i] !== BW'(1000 + i)) bad_d++;
    check("t2_order", BW'(bad_d), BW'(0));
    mn = 999;
    for (int i = gbase; i < gaps.size(); i++)
      if (gaps[i] < mn) mn = gaps[i];
    check("t2_gap_min", BW'(mn), BW'(2));

    // Test 3: output capture
    do_reset();
    for (int c = 0; c <= 19; c++) begin
      @(negedge clk);
      fft_next_out = (c == 0);
      fft_out = (c >= 1 && c <= 16) ? BW'(32'hA0 + c - 1) : '0;
      check("t3_valid", BW'(out_valid), BW'(c >= 2 && c <= 17));
      if (c >= 2 && c <= 17)
        check("t3_data", out_data, BW'(32'hA0 + c - 2));
      check("t3_last", BW'(out_last), BW'(c == 17));
      if (c == 16) check("t3_fout_pre", BW'(frames_out), BW'(0));
      if (c == 17) check("t3_frames_out", BW'(frames_out), BW'(1));
      if (c == 10) check("t3_busy", BW'(busy), BW'(1));
    end
    fft_next_out = 1'b0;
    check("t3_no_err", BW'({err_timeout, err_overlap}), BW'(0));

    // Test 4: missing next_out -> timeout
    do_reset();
    @(negedge clk);
    push_n(16, 300);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (fft_next) found = 1;
      else @(negedge clk);
    end
    check("t4_next_seen", BW'(found), BW'(1));
    rise = -1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (err_timeout && rise < 0) rise = c;
      if (c == 10) check("t4_busy_mid", BW'(busy), BW'(1));
    end
    check("t4_latency", BW'(rise), BW'(ML));
    check("t4_busy_end", BW'(busy), BW'(0));
    check("t4_no_ovl", BW'(err_overlap), BW'(0));

    // Test 5: overlapping next_out
    do_reset();
    lasts = 0;
    for (int c = 0; c <= 24; c++) begin
      @(negedge clk);
      fft_next_out = (c == 0 || c == 5);
      fft_out = BW'(32'hB0 + c);
      if (c >= 2 && c <= 5)
        check("t5_f1_data", out_data, BW'(32'hB0 + c - 1));
      if (c >= 7 && c <= 22) begin
        check("t5_valid", BW'(out_valid), BW'(1));
        check("t5_data", out_data, BW'(32'hB0 + c - 1));
      end
      if (c == 5) check("t5_ovl_pre", BW'(err_overlap), BW'(0));
      if (c == 6) check("t5_ovl", BW'(err_overlap), BW'(1));
      if (c < 22 && out_last) lasts++;
      if (c == 22) begin
        check("t5_last", BW'(out_last), BW'(1));
        check("t5_frames_out", BW'(frames_out), BW'(1));
      end
      if (c == 23) check("t5_valid_end", BW'(out_valid), BW'(0));
    end
    fft_next_out = 1'b0;
    check("t5_early_last", BW'(lasts), BW'(0));

    // Test 6: reset mid-stream
    do_reset();
    @(negedge clk);
    push_n(20, 500);
    check("t6_streaming", BW'(busy), BW'(1));
    reset = 1'b1;
    #1;
    check("t6_rst_fft_in", fft_in, '0);
    check("t6_rst_ctl", BW'({fft_next, busy, in_ready}), BW'(0));
    check("t6_rst_frames", BW'(frames_in), BW'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t6_rdy", BW'(in_ready), BW'(1));
    check("t6_idle", BW'(busy), BW'(0));
    nb = n_next;
    repeat (10) @(negedge clk);
    check("t6_no_next", BW'(n_next - nb), BW'(0));
    push_n(15, 700);
    repeat (5) @(negedge clk);
    check("t6_no_next15", BW'(n_next - nb), BW'(0));
    push_n(1, 715);
    check("t6_next_early", BW'(fft_next), BW'(0));
    @(negedge clk);
    check("t6_next", BW'(fft_next), BW'(1));
    @(negedge clk);
    check("t6_first_beat", fft_in, BW'(700));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
